// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the OTG host-port interface master.
package otg_hpi_pkg;

  // FSM encodings, kept as plain constants for compatibility with older tooling
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/otg_hpi_master.sv
// Avalon-MM slave running timed setup/strobe/hold cycles on the 16-bit OTG host port.
module otg_hpi_master
  import otg_hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dir_e              dir_q, dir_d;
  logic [1:0]        addr_q, addr_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic [15:0]       dout_q, dout_d;
  logic              oe_q, oe_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              unused_wdata_hi;

  assign unused_wdata_hi = ^writedata[31:16];

  // Next-state logic: a write wins over a simultaneous read; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    cs_n_d  = cs_n_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (write) begin
          addr_d  = address;
          dout_d  = writedata[15:0];
          oe_d    = 1'b1;
          cs_n_d  = 1'b0;
          dir_d   = DIR_WR;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end else if (read) begin
          addr_d  = address;
          oe_d    = 1'b0;
          cs_n_d  = 1'b0;
          dir_d   = DIR_RD;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          rd_n_d  = (dir_q == DIR_WR);
          wr_n_d  = (dir_q == DIR_RD);
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
          // Bus is sampled on the strobe-release edge, while the device is still driving
          if (dir_q == DIR_RD) begin
            rdata_d = otg_data_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pad registers; reset drops CS and both strobes immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      dir_q   <= DIR_RD;
      addr_q  <= 2'd0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      dout_q  <= 16'h0000;
      oe_q    <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
    end
  end

  assign waitrequest  = !((state_q == ST_HOLD) && (cnt_q == CNT_ZERO));
  assign readdata     = {16'h0000, rdata_q};
  assign otg_addr     = addr_q;
  assign otg_cs_n     = cs_n_q;
  assign otg_rd_n     = rd_n_q;
  assign otg_wr_n     = wr_n_q;
  assign otg_data_out = dout_q;
  assign otg_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_master.sv
// Scoreboard bench: two instances (default timing and 2/1/3 timing) driven in lockstep.
module tb_otg_hpi_master;
  import otg_hpi_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  av_addr;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_wdata;
  logic [15:0] pad_din;

  logic [31:0] a_readdata, b_readdata;
  logic        a_wait, b_wait;
  logic [1:0]  a_addr, b_addr;
  logic        a_cs_n, b_cs_n, a_rd_n, b_rd_n, a_wr_n, b_wr_n;
  logic [15:0] a_dout, b_dout;
  logic        a_oe, b_oe;

  otg_hpi_master dut_a (
    .clk(clk), .reset_n(reset_n), .address(av_addr), .read(av_read), .write(av_write),
    .writedata(av_wdata), .readdata(a_readdata), .waitrequest(a_wait), .otg_addr(a_addr),
    .otg_cs_n(a_cs_n), .otg_rd_n(a_rd_n), .otg_wr_n(a_wr_n), .otg_data_out(a_dout),
    .otg_data_oe(a_oe), .otg_data_in(pad_din)
  );

  otg_hpi_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(av_addr), .read(av_read), .write(av_write),
    .writedata(av_wdata), .readdata(b_readdata), .waitrequest(b_wait), .otg_addr(b_addr),
    .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n), .otg_data_out(b_dout),
    .otg_data_oe(b_oe), .otg_data_in(pad_din)
  );

  logic [1:0]  cs_v, rd_v, wr_v, wait_v, oe_v;
  logic [1:0]  addr_v [2];
  logic [15:0] dout_v [2];
  logic [31:0] rdata_v [2];
  assign cs_v   = {b_cs_n, a_cs_n};
  assign rd_v   = {b_rd_n, a_rd_n};
  assign wr_v   = {b_wr_n, a_wr_n};
  assign wait_v = {b_wait, a_wait};
  assign oe_v   = {b_oe, a_oe};
  assign addr_v[0] = a_addr;      assign addr_v[1] = b_addr;
  assign dout_v[0] = a_dout;      assign dout_v[1] = b_dout;
  assign rdata_v[0] = a_readdata; assign rdata_v[1] = b_readdata;

  // Hand-derived timing: strobe offset from first CS-low cycle, strobe length, CS-low length
  localparam int EXP_OFF [2] = '{1, 2};
  localparam int EXP_LEN [2] = '{4, 1};
  localparam int EXP_CS  = 6;
  localparam int EXP_LAT = 6;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] dout;
    logic        oe;
    logic [31:0] rdata;
    bit          is_wr;
    int          req_cyc;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int cs_run [2];
  int gap_run [2];
  int gap_seen [2];
  int off [2];
  int wr_len [2];
  int rd_len [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, required %h", nm, i, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_cs_n"}, i, 32'(cs_v[i]), 32'd1);
      chk({tag, "_rd_n"}, i, 32'(rd_v[i]), 32'd1);
      chk({tag, "_wr_n"}, i, 32'(wr_v[i]), 32'd1);
      chk({tag, "_oe"}, i, 32'(oe_v[i]), 32'd0);
      chk({tag, "_dout"}, i, 32'(dout_v[i]), 32'd0);
      chk({tag, "_addr"}, i, 32'(addr_v[i]), 32'd0);
      chk({tag, "_readdata"}, i, rdata_v[i], 32'd0);
      chk({tag, "_wait"}, i, 32'(wait_v[i]), 32'd1);
    end
  endtask

  // Issue one transfer, push its expectation, wait for completion; hold keeps the request up
  task automatic xfer(input logic r, input logic w, input logic [1:0] a, input logic [31:0] wd,
                      input logic [15:0] din, input logic [15:0] exp_dout,
                      input logic [31:0] exp_rdata, input int gap, input bit hold);
    exp_t e;
    bit done;
    av_read  = r;
    av_write = w;
    av_addr  = a;
    av_wdata = wd;
    pad_din  = din;
    e.addr = a; e.dout = exp_dout; e.oe = w; e.rdata = exp_rdata;
    e.is_wr = w; e.req_cyc = cyc; e.gap = gap;
    exp_q.push_back(e);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!a_wait) done = 1'b1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL timeout: waitrequest still 1 after 40 cycles, required 0");
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      av_read  = 1'b0;
      av_write = 1'b0;
    end
  endtask

  // Monitor: per-cycle pin invariants, pops the scoreboard whenever waitrequest drops
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          cs_run[i] = 0; gap_run[i] = 100; gap_seen[i] = 100;
          off[i] = -1; wr_len[i] = 0; rd_len[i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if ((!rd_v[i] && !wr_v[i]) || ((!rd_v[i] || !wr_v[i]) && cs_v[i])) begin
            fails++;
            $display("FAIL strobe_rule dut%0d: rd_n=%b wr_n=%b cs_n=%b, required exclusive strobes under CS",
                     i, rd_v[i], wr_v[i], cs_v[i]);
          end
          if (!cs_v[i]) begin
            if (cs_run[i] == 0) begin
              gap_seen[i] = gap_run[i];
              wr_len[i] = 0; rd_len[i] = 0; off[i] = -1;
            end
            if ((!wr_v[i] || !rd_v[i]) && off[i] < 0) off[i] = cs_run[i];
            if (!wr_v[i]) wr_len[i]++;
            if (!rd_v[i]) rd_len[i]++;
            cs_run[i]++;
            gap_run[i] = 0;
          end else begin
            cs_run[i] = 0;
            gap_run[i]++;
          end
        end
        if (!wait_v[0] || !wait_v[1]) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: waitrequest=%b with no transfer outstanding", wait_v);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 2; i++) begin
              chk("waitrequest", i, 32'(wait_v[i]), 32'd0);
              chk("latency", i, 32'(cyc - e.req_cyc), 32'(EXP_LAT));
              chk("otg_addr", i, 32'(addr_v[i]), 32'(e.addr));
              chk("otg_data_out", i, 32'(dout_v[i]), 32'(e.dout));
              chk("otg_data_oe", i, 32'(oe_v[i]), 32'(e.oe));
              chk("readdata", i, rdata_v[i], e.rdata);
              chk("cs_len", i, 32'(cs_run[i]), 32'(EXP_CS));
              chk("strobe_off", i, 32'(off[i]), 32'(EXP_OFF[i]));
              chk("wr_len", i, 32'(wr_len[i]), e.is_wr ? 32'(EXP_LEN[i]) : 32'd0);
              chk("rd_len", i, 32'(rd_len[i]), e.is_wr ? 32'd0 : 32'(EXP_LEN[i]));
              if (e.gap != 0) chk("cs_gap", i, 32'(gap_seen[i]), 32'(e.gap));
            end
          end
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    av_read  = 1'b0;
    av_write = 1'b0;
    av_addr  = 2'd0;
    av_wdata = 32'h0000_0000;
    pad_din  = 16'h0000;
    #12;
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain write, then read, then simultaneous read+write (write wins, readdata kept)
    xfer(1'b0, 1'b1, HPI_ADDR, 32'hABCD_1234, 16'h0000, 16'h1234, 32'h0000_0000, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    xfer(1'b1, 1'b0, HPI_DATA, 32'h0000_0000, 16'hBEEF, 16'h1234, 32'h0000_BEEF, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    xfer(1'b1, 1'b1, HPI_MAILBOX, 32'h0000_5A5A, 16'h1111, 16'h5A5A, 32'h0000_BEEF, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back read then write with the request line never dropped
    xfer(1'b1, 1'b0, HPI_STATUS, 32'h0000_0000, 16'h1357, 16'h5A5A, 32'h0000_1357, 0, 1'b1);
    xfer(1'b0, 1'b1, HPI_MAILBOX, 32'h0000_C0DE, 16'h0000, 16'hC0DE, 32'h0000_1357, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a write strobe
    av_write = 1'b1;
    av_addr  = HPI_ADDR;
    av_wdata = 32'hFFFF_0F0F;
    repeat (4) @(negedge clk);
    chk("pre_reset_wr_n", 0, 32'(a_wr_n), 32'd0);
    chk("pre_reset_wr_n", 1, 32'(b_wr_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    av_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    xfer(1'b1, 1'b0, HPI_ADDR, 32'h0000_0000, 16'h2468, 16'h0000, 32'h0000_2468, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 0, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
